// File: rtl/mlu_pkg.sv
// mlu_pkg -- shared definitions for the mask logic unit stream.
//   mode_t        : per-pixel 2-bit operation selector
//   *_FIELD       : channel index inside a packed {r,g,b} colour word
//   field_lsb()   : bit offset of a channel field for a given channel width
package mlu_pkg;

    typedef enum logic [1:0] {
        MODE_KEEP  = 2'b00,
        MODE_PRIM  = 2'b01,
        MODE_SEC   = 2'b10,
        MODE_BLEND = 2'b11
    } mode_t;

    // Packed colour is {r, g, b} with red in the MSBs.
    localparam int R_FIELD = 2;
    localparam int G_FIELD = 1;
    localparam int B_FIELD = 0;

    function automatic int field_lsb(input int field, input int cbits);
        return field * cbits;
    endfunction

endpackage

// File: rtl/mlu_pixel.sv
// mlu_pixel -- combinational single-pixel mask operation.
// Optional feature macro: MLU_BLEND_EN (mode 11 blends with primary; when
// undefined mode 11 passes the input through and no adders are built).
// Ports:
//   i_r, i_g, i_b    : input pixel channels
//   i_mode           : 2-bit mode (KEEP / PRIM / SEC / BLEND)
//   i_primary        : packed {r,g,b} primary colour
//   i_secondary      : packed {r,g,b} secondary colour
//   o_r, o_g, o_b    : resulting pixel channels
module mlu_pixel
    import mlu_pkg::*;
#(
    parameter int CBITS = 4
) (
    input  logic [CBITS-1:0]   i_r,
    input  logic [CBITS-1:0]   i_g,
    input  logic [CBITS-1:0]   i_b,
    input  logic [1:0]         i_mode,
    input  logic [3*CBITS-1:0] i_primary,
    input  logic [3*CBITS-1:0] i_secondary,
    output logic [CBITS-1:0]   o_r,
    output logic [CBITS-1:0]   o_g,
    output logic [CBITS-1:0]   o_b
);

    localparam int R_LSB = field_lsb(R_FIELD, CBITS);
    localparam int G_LSB = field_lsb(G_FIELD, CBITS);
    localparam int B_LSB = field_lsb(B_FIELD, CBITS);

    logic [CBITS-1:0] w_pri_r, w_pri_g, w_pri_b;
    logic [CBITS-1:0] w_sec_r, w_sec_g, w_sec_b;
    mode_t            w_mode;

    assign w_pri_r = i_primary[R_LSB +: CBITS];
    assign w_pri_g = i_primary[G_LSB +: CBITS];
    assign w_pri_b = i_primary[B_LSB +: CBITS];
    assign w_sec_r = i_secondary[R_LSB +: CBITS];
    assign w_sec_g = i_secondary[G_LSB +: CBITS];
    assign w_sec_b = i_secondary[B_LSB +: CBITS];
    assign w_mode  = mode_t'(i_mode);

`ifdef MLU_BLEND_EN
    // One extra bit keeps the carry; dropping the LSB halves the sum.
    logic [CBITS:0] w_sum_r, w_sum_g, w_sum_b;
    assign w_sum_r = {1'b0, i_r} + {1'b0, w_pri_r};
    assign w_sum_g = {1'b0, i_g} + {1'b0, w_pri_g};
    assign w_sum_b = {1'b0, i_b} + {1'b0, w_pri_b};
`endif

    always_comb begin
        o_r = i_r;
        o_g = i_g;
        o_b = i_b;
        case (w_mode)
            MODE_PRIM: begin
                o_r = w_pri_r;
                o_g = w_pri_g;
                o_b = w_pri_b;
            end
            MODE_SEC: begin
                o_r = w_sec_r;
                o_g = w_sec_g;
                o_b = w_sec_b;
            end
`ifdef MLU_BLEND_EN
            MODE_BLEND: begin
                o_r = w_sum_r[CBITS:1];
                o_g = w_sum_g[CBITS:1];
                o_b = w_sum_b[CBITS:1];
            end
`endif
            default: begin
                // KEEP (and BLEND when blending is not built): pass through.
            end
        endcase
    end

endmodule

// File: rtl/mlu_stream.sv
// mlu_stream -- two-stage valid/ready pipeline applying a per-pixel mode mask
// to LANES x PIXELS planar RGB pixels, one beat per clock.
// Optional feature macro: MLU_BLEND_EN (enables mode 11 blending in mlu_pixel).
// Ports:
//   clk, rst_n                    : clock, asynchronous active-low reset
//   in_valid / in_ready           : input handshake
//   in_reds/greens/blues, in_mask : planar pixel data and per-pixel modes
//   primary, secondary            : packed {r,g,b} colours sampled with the beat
//   out_valid / out_ready         : output handshake
//   out_reds/greens/blues         : registered results
//   beat_count                    : consumed output beats since reset (wraps)
module mlu_stream
    import mlu_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int PIXELS = 64,
    parameter int CBITS  = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [LANES*PIXELS*CBITS-1:0]   in_reds,
    input  logic [LANES*PIXELS*CBITS-1:0]   in_greens,
    input  logic [LANES*PIXELS*CBITS-1:0]   in_blues,
    input  logic [LANES*PIXELS*2-1:0]       in_mask,
    input  logic [3*CBITS-1:0]              primary,
    input  logic [3*CBITS-1:0]              secondary,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [LANES*PIXELS*CBITS-1:0]   out_reds,
    output logic [LANES*PIXELS*CBITS-1:0]   out_greens,
    output logic [LANES*PIXELS*CBITS-1:0]   out_blues,
    output logic [15:0]                     beat_count
);

    localparam int NPIX = LANES * PIXELS;
    localparam int DW   = NPIX * CBITS;
    localparam int MW   = NPIX * 2;
    localparam int CW   = 3 * CBITS;

    // Stage 1: captured input beat.
    logic          r_s1_valid;
    logic [DW-1:0] r_s1_reds, r_s1_greens, r_s1_blues;
    logic [MW-1:0] r_s1_mask;
    logic [CW-1:0] r_s1_primary, r_s1_secondary;

    // Stage 2: computed result, drives the outputs directly.
    logic          r_s2_valid;
    logic [DW-1:0] r_out_reds, r_out_greens, r_out_blues;
    logic [15:0]   r_beat_count;

    logic          w_s1_adv;
    logic          w_accept;
    logic          w_consume;
    logic [DW-1:0] w_res_reds, w_res_greens, w_res_blues;

    // Stage 1 may move on whenever stage 2 is empty or is being drained;
    // this also lets bubbles in stage 2 be filled without a stall.
    assign w_s1_adv  = !r_s2_valid || out_ready;
    assign in_ready  = !r_s1_valid || w_s1_adv;
    assign w_accept  = in_valid && in_ready;
    assign w_consume = r_s2_valid && out_ready;

    for (genvar gi = 0; gi < NPIX; gi++) begin : g_pix
        mlu_pixel #(
            .CBITS (CBITS)
        ) u_pixel (
            .i_r         (r_s1_reds  [gi*CBITS +: CBITS]),
            .i_g         (r_s1_greens[gi*CBITS +: CBITS]),
            .i_b         (r_s1_blues [gi*CBITS +: CBITS]),
            .i_mode      (r_s1_mask  [gi*2 +: 2]),
            .i_primary   (r_s1_primary),
            .i_secondary (r_s1_secondary),
            .o_r         (w_res_reds  [gi*CBITS +: CBITS]),
            .o_g         (w_res_greens[gi*CBITS +: CBITS]),
            .o_b         (w_res_blues [gi*CBITS +: CBITS])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid     <= 1'b0;
            r_s1_reds      <= '0;
            r_s1_greens    <= '0;
            r_s1_blues     <= '0;
            r_s1_mask      <= '0;
            r_s1_primary   <= '0;
            r_s1_secondary <= '0;
        end else begin
            if (w_accept) begin
                r_s1_valid     <= 1'b1;
                r_s1_reds      <= in_reds;
                r_s1_greens    <= in_greens;
                r_s1_blues     <= in_blues;
                r_s1_mask      <= in_mask;
                r_s1_primary   <= primary;
                r_s1_secondary <= secondary;
            end else if (w_s1_adv) begin
                r_s1_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid   <= 1'b0;
            r_out_reds   <= '0;
            r_out_greens <= '0;
            r_out_blues  <= '0;
        end else if (w_s1_adv) begin
            r_s2_valid <= r_s1_valid;
            // Only a real beat overwrites the output data; an empty stage 1
            // leaves the last result in place while out_valid is low.
            if (r_s1_valid) begin
                r_out_reds   <= w_res_reds;
                r_out_greens <= w_res_greens;
                r_out_blues  <= w_res_blues;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat_count <= '0;
        end else if (w_consume) begin
            r_beat_count <= r_beat_count + 16'd1;
        end
    end

    assign out_valid  = r_s2_valid;
    assign out_reds   = r_out_reds;
    assign out_greens = r_out_greens;
    assign out_blues  = r_out_blues;
    assign beat_count = r_beat_count;

endmodule

// File: tb/tb_mlu_stream.sv
module tb_mlu_stream;

    localparam int LANES  = 4;
    localparam int PIXELS = 64;
    localparam int CBITS  = 4;
    localparam int NPIX   = LANES * PIXELS;
    localparam int N      = NPIX * CBITS;
    localparam int M      = NPIX * 2;
`ifdef MLU_BLEND_EN
    localparam bit BLEND_ON = 1'b1;
`else
    localparam bit BLEND_ON = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [N-1:0]       in_reds, in_greens, in_blues;
    logic [M-1:0]       in_mask;
    logic [3*CBITS-1:0] primary, secondary;
    logic               out_valid;
    logic               out_ready;
    logic [N-1:0]       out_reds, out_greens, out_blues;
    logic [15:0]        beat_count;

    mlu_stream #(.LANES(LANES), .PIXELS(PIXELS), .CBITS(CBITS)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_reds    (in_reds),
        .in_greens  (in_greens),
        .in_blues   (in_blues),
        .in_mask    (in_mask),
        .primary    (primary),
        .secondary  (secondary),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_reds   (out_reds),
        .out_greens (out_greens),
        .out_blues  (out_blues),
        .beat_count (beat_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] r;
        logic [N-1:0] g;
        logic [N-1:0] b;
        int           acc_edge;
    } beat_t;

    beat_t        q[$];
    beat_t        cur_exp;
    logic [15:0]  m_beats;
    int           edge_no, n_acc, n_cons;
    int           first_acc_edge, first_cons_edge, last_cons_edge;
    bit           hold_prev;
    logic [N-1:0] prev_r, prev_g, prev_b;
    int           n_checks = 0;
    int           n_err    = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        int d;
        d = -1;
        for (int i = N - 1; i >= 0; i--) if (obs[i] !== exp[i]) d = i;
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h (low 256 bits, first diff bit %0d)",
                   tag, obs[255:0], exp[255:0], d);
        end
    endtask

    // Reference: every pixel independently picks keep / primary / secondary /
    // average-with-primary according to its mode.
    task automatic compute_exp();
        int ch[3], pc[3], sc[3], md, res;
        for (int p = 0; p < NPIX; p++) begin
            ch[0] = int'(in_reds  [p*CBITS +: CBITS]);
            ch[1] = int'(in_greens[p*CBITS +: CBITS]);
            ch[2] = int'(in_blues [p*CBITS +: CBITS]);
            for (int c = 0; c < 3; c++) begin
                pc[c] = int'(primary  [(2-c)*CBITS +: CBITS]);
                sc[c] = int'(secondary[(2-c)*CBITS +: CBITS]);
            end
            md = int'(in_mask[p*2 +: 2]);
            for (int c = 0; c < 3; c++) begin
                if (md == 1)                 res = pc[c];
                else if (md == 2)            res = sc[c];
                else if (md == 3 && BLEND_ON) res = (ch[c] + pc[c]) / 2;
                else                         res = ch[c];
                if (c == 0) cur_exp.r[p*CBITS +: CBITS] = CBITS'(res);
                if (c == 1) cur_exp.g[p*CBITS +: CBITS] = CBITS'(res);
                if (c == 2) cur_exp.b[p*CBITS +: CBITS] = CBITS'(res);
            end
        end
    endtask

    task automatic set_beat();
        for (int i = 0; i < N / 32; i++) begin
            in_reds  [i*32 +: 32] = $urandom();
            in_greens[i*32 +: 32] = $urandom();
            in_blues [i*32 +: 32] = $urandom();
        end
        for (int i = 0; i < M / 32; i++) in_mask[i*32 +: 32] = $urandom();
        primary   = (3*CBITS)'($urandom());
        secondary = (3*CBITS)'($urandom());
        compute_exp();
    endtask

    task automatic clear_model();
        q.delete();
        m_beats   = '0;
        hold_prev = 1'b0;
        n_acc     = 0;
        n_cons    = 0;
    endtask

    // One clock of the running stream: check at the falling edge, then step
    // the scoreboard according to the handshakes seen before the rising edge.
    task automatic cycle();
        bit acc, cons, exp_ov;
        beat_t b;
        @(negedge clk);
        acc    = in_valid && in_ready;
        cons   = out_valid && out_ready;
        exp_ov = (q.size() > 0) && (q[0].acc_edge < edge_no);
        chk("beat_count", N'(beat_count), N'(m_beats));
        chk("out_valid", N'(out_valid), N'(exp_ov));
        chk("in_ready", N'(in_ready), N'((q.size() < 2) || out_ready));
        if (hold_prev) begin
            chk("hold_reds", out_reds, prev_r);
            chk("hold_greens", out_greens, prev_g);
            chk("hold_blues", out_blues, prev_b);
        end
        if (cons) begin
            chk("consume_nonempty", N'(q.size() > 0), N'(1));
            if (q.size() > 0) begin
                chk("out_reds", out_reds, q[0].r);
                chk("out_greens", out_greens, q[0].g);
                chk("out_blues", out_blues, q[0].b);
                void'(q.pop_front());
            end
        end
        hold_prev = out_valid && !out_ready;
        prev_r = out_reds;
        prev_g = out_greens;
        prev_b = out_blues;
        @(posedge clk);
        edge_no++;
        if (acc) begin
            if (n_acc == 0) first_acc_edge = edge_no;
            b = cur_exp;
            b.acc_edge = edge_no;
            q.push_back(b);
            n_acc++;
        end
        if (cons) begin
            if (n_cons == 0) first_cons_edge = edge_no;
            last_cons_edge = edge_no;
            m_beats = m_beats + 16'd1;
            n_cons++;
        end
        #1;
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_out_valid"}, N'(out_valid), N'(0));
        chk({tag, "_in_ready"}, N'(in_ready), N'(1));
        chk({tag, "_beat_count"}, N'(beat_count), N'(0));
        chk({tag, "_out_reds"}, out_reds, '0);
        chk({tag, "_out_greens"}, out_greens, '0);
        chk({tag, "_out_blues"}, out_blues, '0);
    endtask

    task automatic full_reset(input string tag);
        rst_n = 1'b0;
        set_beat();
        in_valid  = 1'($urandom());
        out_ready = 1'($urandom());
        repeat (3) @(posedge clk);
        #1;
        reset_checks(tag);
        @(negedge clk);
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        clear_model();
        @(posedge clk);
        edge_no++;
        #1;
    endtask

    task automatic drain(input string tag);
        int guard;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        guard = 0;
        while ((q.size() > 0 || out_valid) && guard < 10) begin
            cycle();
            guard++;
        end
        repeat (2) cycle();
        chk({tag, "_drained"}, N'(q.size()), N'(0));
    endtask

    int exp_r[4], exp_g[4], exp_b[4];
    logic [N-1:0] rep_r, rep_g, rep_b;
    logic [15:0]  base;
    int           guard;

    initial begin
        edge_no = 0;
        clear_model();
        first_acc_edge = 0; first_cons_edge = 0; last_cons_edge = 0;

        // Reset with random inputs.
        full_reset("reset");

        // Directed modes: pixel (8,2,F), primary F00, secondary 0A5.
        exp_r = '{8, 15, 0, BLEND_ON ? 11 : 8};
        exp_g = '{2, 0, 10, BLEND_ON ? 1 : 2};
        exp_b = '{15, 0, 5, BLEND_ON ? 7 : 15};
        for (int k = 0; k < 4; k++) begin
            for (int p = 0; p < NPIX; p++) begin
                in_reds  [p*CBITS +: CBITS] = 4'h8;
                in_greens[p*CBITS +: CBITS] = 4'h2;
                in_blues [p*CBITS +: CBITS] = 4'hF;
                in_mask  [p*2 +: 2]         = 2'(k);
                rep_r[p*CBITS +: CBITS] = CBITS'(exp_r[k]);
                rep_g[p*CBITS +: CBITS] = CBITS'(exp_g[k]);
                rep_b[p*CBITS +: CBITS] = CBITS'(exp_b[k]);
            end
            primary   = 12'hF00;
            secondary = 12'h0A5;
            compute_exp();
            in_valid  = 1'b1;
            out_ready = 1'b1;
            cycle();
            in_valid = 1'b0;
            guard = 0;
            while (!out_valid && guard < 5) begin
                cycle();
                guard++;
            end
            chk("mode_valid_seen", N'(out_valid), N'(1));
            chk($sformatf("mode%0d_reds", k), out_reds, rep_r);
            chk($sformatf("mode%0d_greens", k), out_greens, rep_g);
            chk($sformatf("mode%0d_blues", k), out_blues, rep_b);
            cycle();
        end
        drain("modes");

        // Throughput: 100 back-to-back beats with out_ready high.
        base   = m_beats;
        n_acc  = 0;
        n_cons = 0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            set_beat();
            cycle();
        end
        drain("thru");
        chk("thru_accepts", N'(n_acc), N'(100));
        chk("thru_consumes", N'(n_cons), N'(100));
        chk("thru_latency", N'(first_cons_edge - first_acc_edge), N'(2));
        chk("thru_contiguous", N'(last_cons_edge - first_cons_edge), N'(99));
        chk("thru_beat_count", N'(beat_count), N'(base + 16'd100));

        // Backpressure: two beats fill the pipe, then in_ready drops.
        n_acc = 0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_beat();
            cycle();
        end
        chk("bp_accepts", N'(n_acc), N'(2));
        chk("bp_in_ready_low", N'(in_ready), N'(0));
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_back", N'(in_ready), N'(1));
        set_beat();
        cycle();   // consume, advance and accept on the same edge
        chk("bp_three_way", N'(n_acc), N'(3));
        drain("bp");

        // Random handshakes.
        for (int i = 0; i < 300; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            set_beat();
            cycle();
        end
        drain("rand");

        // Mid-stream reset with both stages full.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        repeat (3) begin
            set_beat();
            cycle();
        end
        chk("mid_full", N'(out_valid && !in_ready), N'(1));
        #2;
        rst_n = 1'b0;
        #1;
        reset_checks("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        clear_model();
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        edge_no++;
        #1;
        set_beat();
        in_valid = 1'b1;
        cycle();
        in_valid = 1'b0;
        repeat (6) cycle();
        chk("midrst_single", N'(n_cons), N'(1));
        chk("midrst_count", N'(beat_count), N'(1));

        // Wrap: 65537 consumed beats from reset.
        full_reset("wrap_reset");
        set_beat();
        in_valid  = 1'b1;
        out_ready = 1'b1;
        guard = 0;
        while (n_cons < 65537 && guard < 65700) begin
            if (n_acc >= 65537) in_valid = 1'b0;
            cycle();
            guard++;
        end
        chk("wrap_consumed", N'(n_cons), N'(65537));
        chk("wrap_beat_count", N'(beat_count), N'(16'd1));
        drain("wrap");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
